// File: rtl/riscv_pkg.sv
// Shared RV32I multi-cycle encodings: opcodes, controller states and datapath
// mux/ALU select values used by both the controller and the datapath.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMRD,
        S_MEMWR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory completion strobe and flags a
// timeout when WAIT_MAX cycles have elapsed without one.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic timeout
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] count;

    // A ready strobe in the same cycle the limit is reached still wins.
    assign timeout = count_en & ~ready & (count == CW'(WAIT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !ready && !timeout) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/write-back,
// counts retired instructions and traps on illegal opcodes or memory timeout.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int unsigned WAIT_MAX   = 15,
    parameter int unsigned CNT_W      = 32,
    parameter bit          ENABLE_JAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_src,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    state_t state, state_next;
    logic   timer_clear, timer_en, timeout;

    assign timer_en    = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timer_clear = (state_next != state);

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .count_en (timer_en),
        .ready    (mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_next;
            // TRAP is absorbing, so any arrival in FETCH from elsewhere is a retirement.
            if (state != S_FETCH && state_next == S_FETCH) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = WB_ALUOUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        pc_src     = 1'b0;
        trap       = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (timeout) begin
                    state_next = S_TRAP;
                end else if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R, OP_I, OP_LW, OP_SW: state_next = S_EXEC;
                    OP_BRANCH: state_next = (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_BRANCH : S_TRAP;
                    OP_JAL:    state_next = ENABLE_JAL ? S_JUMP : S_TRAP;
                    default:   state_next = S_TRAP;
                endcase
            end
            S_EXEC: begin
                alu_src_a = SRC_A_RS1;
                case (opcode)
                    OP_R: begin
                        alu_src_b  = SRC_B_RS2;
                        alu_op     = ALU_RFUNCT;
                        state_next = S_WB_ALU;
                    end
                    OP_I: begin
                        alu_src_b  = SRC_B_IMM;
                        alu_op     = ALU_IFUNCT;
                        state_next = S_WB_ALU;
                    end
                    OP_LW: begin
                        alu_src_b  = SRC_B_IMM;
                        state_next = S_MEMRD;
                    end
                    OP_SW: begin
                        alu_src_b  = SRC_B_IMM;
                        state_next = S_MEMWR;
                    end
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                if (timeout)        state_next = S_TRAP;
                else if (mem_ready) state_next = S_WB_MEM;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                if (timeout)        state_next = S_TRAP;
                else if (mem_ready) state_next = S_FETCH;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_ALUOUT;
                state_next = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_SUB;
                pc_src     = 1'b1;
                pc_write   = ((funct3 == F3_BEQ) & zero) | ((funct3 == F3_BNE) & ~zero);
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = WB_PC4;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_next = S_TRAP;
        endcase

        // The state register resets asynchronously, but these must drop combinationally too.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            trap      = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised FSM controller for the multi-cycle RV32I datapath; it replaces the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and write-back per instruction, handshakes with a variable-latency memory, counts retired instructions, and traps on illegal opcodes or memory timeout. It sits between the instruction register and the datapath muxes, register-file write enable and PC enable.

## Interface
- `WAIT_MAX`, 15: maximum cycles to wait for `mem_ready` before trapping (1..255).
- `CNT_W`, 32: width of the retired-instruction counter.
- `ENABLE_JAL`, 1: 1 = JAL supported; 0 = JAL opcode is illegal.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `opcode` in 7: IR[6:0]; valid from DECODE onward.
- `funct3` in 3: IR[14:12].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completion strobe for the current access.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: load IR (and latch old PC).
- `pc_write` out 1: load PC.
- `reg_write` out 1: register-file write enable.
- `mem_to_reg` out 2: write-back source. 00 = ALUOut, 01 = MDR, 10 = old PC + 4.
- `alu_src_a` out 2: ALU A source. 00 = PC, 01 = rs1, 10 = old PC.
- `alu_src_b` out 2: ALU B source. 00 = rs2, 01 = const 4, 10 = imm.
- `alu_op` out 2: ALU op. 00 = add, 01 = sub, 10 = R-funct, 11 = I-funct.
- `pc_src` out 1: PC source. 0 = ALU result, 1 = ALUOut.
- `trap` out 1: sticky error flag.
- `instret` out CNT_W: retired-instruction count.

## Operation
- Supported opcodes: R-type 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BRANCH 1100011 (funct3 000 BEQ, 001 BNE), JAL 1101111.
- States: FETCH, DECODE, EXEC, MEMRD, MEMWR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
- **FETCH**: `mem_read`=1, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, then go to DECODE.
- **DECODE**: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00 (branch target into ALUOut).
  - R / I-ALU / LW / SW → EXEC.
  - BEQ/BNE → BRANCH.
  - JAL (if enabled) → JUMP.
  - Anything else, including branch funct3 not 000/001 → TRAP.
- **EXEC**: `alu_src_a`=01.
  - R: `alu_src_b`=00, `alu_op`=10, then WB_ALU.
  - I-ALU: `alu_src_b`=10, `alu_op`=11, then WB_ALU.
  - LW/SW: `alu_src_b`=10, `alu_op`=00, then MEMRD or MEMWR.
- **MEMRD** / **MEMWR**: hold `mem_read` / `mem_write` until `mem_ready`.
  - MEMRD → WB_MEM.
  - MEMWR → FETCH; the instruction retires.
- **WB_ALU**: `reg_write`=1, `mem_to_reg`=00, then FETCH.
- **WB_MEM**: `reg_write`=1, `mem_to_reg`=01, then FETCH.
- **BRANCH**: `alu_src_a`=01, `alu_src_b`=00, `alu_op`=01, `pc_src`=1.
  - `pc_write` = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Then FETCH.
- **JUMP**: `pc_write`=1, `pc_src`=1, `reg_write`=1, `mem_to_reg`=10, then FETCH.
- **Retirement**: `instret` increments by 1 on every transition into FETCH from any state except TRAP. It wraps modulo 2^CNT_W.
- **Wait counter** (ceil(log2(WAIT_MAX+1)) bits):
  - Clears on entry to FETCH/MEMRD/MEMWR.
  - Increments each cycle in those states without `mem_ready`.
  - When it equals WAIT_MAX and `mem_ready`=0 → TRAP.
  - `mem_ready` in the same cycle the count reaches WAIT_MAX completes normally.
- **TRAP**: all enables 0, `trap`=1. The state is absorbing; only `rst` exits it. `mem_ready` is ignored outside FETCH/MEMRD/MEMWR.

## Timing
- Outputs are combinational from the registered state plus `opcode`/`funct3`/`zero`/`mem_ready`. No output depends on `mem_ready` except `ir_write`/`pc_write` in FETCH.
- **Reset**: state=FETCH, `instret`=0, wait counter=0, `trap`=0. All enables are 0 during reset, except `mem_read`=1 once `rst` deasserts.
- **Reset mid-operation**: aborts immediately, asynchronously. No write enable may be asserted while `rst`=1.
- **Latency with zero-wait memory** (`mem_ready` high in the first cycle):
  - R / I-ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 3 cycles.
- Each memory wait cycle adds exactly 1 cycle.

## Structure
- Shared package `riscv_pkg`: opcode localparams, state encoding, `alu_op` / `alu_src` / `mem_to_reg` encodings. The datapath uses the same package.
- One sub-module, `mem_wait_timer`, parametrised by WAIT_MAX. Ports: clear, count-enable, ready → timeout pulse.
- The FSM and `instret` live in the top.

## Test plan
- **Reset, zero-wait**: reset, then R-type 0110011 with `mem_ready`=1 in FETCH.
  - Expect states FETCH, DECODE, EXEC, WB_ALU.
  - `reg_write`=1 only in cycle 4.
  - `instret` goes 0→1 on cycle 5.
- **LW with waits**: LW with 2 wait cycles in FETCH and 3 in MEMRD.
  - Total 10 cycles.
  - `mem_read` held continuously through the waits.
  - `mem_to_reg`=01 in WB_MEM.
- **Branch decisions**:
  - BEQ with `zero`=1 → `pc_write`=1 in BRANCH.
  - BNE with `zero`=1 → `pc_write`=0.
  - Both take 3 cycles; `instret` +1 each.
- **Timeout**: WAIT_MAX=3, `mem_ready` never asserted in FETCH.
  - TRAP entered after cycle 4; `trap`=1 and stays.
  - Next: `mem_ready` arriving exactly at count 3 → no trap, normal DECODE.
- **Illegal opcodes**:
  - Opcode 1110011 → TRAP from DECODE.
  - ENABLE_JAL=0 with 1101111 → TRAP.
  - `instret` unchanged in both cases.
- **Async reset mid-instruction**: `rst` in MEMWR with `mem_write`=1.
  - Outputs drop within the same cycle.
  - After release: FETCH, `instret`=0, `trap`=0.
  - `instret` wrap with CNT_W=4: 16 retirements → 0.
